// File: rtl/hamming74_nibble_packer.sv
// Hamming(7,4) nibble packer: pulls data nibbles out of corrected codewords, pairs them into
// bytes on a registered valid/ready output and keeps saturating error statistics.
module hamming74_nibble_packer #(
  parameter bit          LSN_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic [2:0]       in_syndrome,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_err,
  output logic             out_partial,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] dat_err_cnt
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

  state_t             state, state_nx;
  logic [NIB_W-1:0]   pend_nib, pend_nib_nx;
  logic               pend_err, pend_err_nx;
  logic               out_valid_nx, out_err_nx, out_partial_nx;
  logic [BYTE_W-1:0]  out_byte_nx;

  logic [NIB_W-1:0]   nib;
  logic               in_err, par_hit, dat_hit;
  logic               slot_free, in_fire;

  assign nib       = {in_code[6], in_code[5], in_code[4], in_code[2]};
  assign in_err    = |in_syndrome;
  assign par_hit   = $onehot(in_syndrome);
  assign dat_hit   = in_err & ~par_hit;
  assign slot_free = ~out_valid | out_ready;
  // In HALF the next codeword completes a byte, so it needs a free output slot.
  assign in_ready  = (state == EMPTY) | slot_free;
  assign in_fire   = in_valid & in_ready;

  // State, pending nibble and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      pend_nib    <= '0;
      pend_err    <= 1'b0;
      out_valid   <= 1'b0;
      out_byte    <= '0;
      out_err     <= 1'b0;
      out_partial <= 1'b0;
    end else begin
      state       <= state_nx;
      pend_nib    <= pend_nib_nx;
      pend_err    <= pend_err_nx;
      out_valid   <= out_valid_nx;
      out_byte    <= out_byte_nx;
      out_err     <= out_err_nx;
      out_partial <= out_partial_nx;
    end
  end

  // Next state and output register load; outputs hold unless a byte is completed or flushed.
  always_comb begin
    state_nx       = state;
    pend_nib_nx    = pend_nib;
    pend_err_nx    = pend_err;
    out_valid_nx   = out_valid & ~out_ready;
    out_byte_nx    = out_byte;
    out_err_nx     = out_err;
    out_partial_nx = out_partial;

    case (state)
      EMPTY: begin
        if (in_fire) begin
          pend_nib_nx = nib;
          pend_err_nx = in_err;
          state_nx    = HALF;
        end
      end
      HALF: begin
        if (in_fire) begin
          out_byte_nx    = LSN_FIRST ? {nib, pend_nib} : {pend_nib, nib};
          out_err_nx     = pend_err | in_err;
          out_partial_nx = 1'b0;
          out_valid_nx   = 1'b1;
          pend_nib_nx    = '0;
          pend_err_nx    = 1'b0;
          state_nx       = EMPTY;
        end else if (flush && slot_free && !in_valid) begin
          out_byte_nx    = LSN_FIRST ? {NIB_W'(0), pend_nib} : {pend_nib, NIB_W'(0)};
          out_err_nx     = pend_err;
          out_partial_nx = 1'b1;
          out_valid_nx   = 1'b1;
          pend_nib_nx    = '0;
          pend_err_nx    = 1'b0;
          state_nx       = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_cnt <= '0;
      dat_err_cnt <= '0;
    end else if (cnt_clr) begin
      par_err_cnt <= '0;
      dat_err_cnt <= '0;
    end else if (in_fire) begin
      if (par_hit && (par_err_cnt != {CNT_W{1'b1}}))
        par_err_cnt <= par_err_cnt + CNT_W'(1);
      if (dat_hit && (dat_err_cnt != {CNT_W{1'b1}}))
        dat_err_cnt <= dat_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming74_nibble_packer.sv
// Bench for hamming74_nibble_packer: two instances (LSN-first/16-bit counters and
// MSN-first/2-bit counters) share all inputs and are checked against one reference model.
module tb_hamming74_nibble_packer;

  localparam int SAT_A = 65535;
  localparam int SAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, flush, out_ready, cnt_clr;
  logic [6:0] in_code;
  logic [2:0] in_syndrome;

  logic        a_in_ready, a_out_valid, a_out_err, a_out_partial;
  logic [7:0]  a_out_byte;
  logic [15:0] a_par_err_cnt, a_dat_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_err, b_out_partial;
  logic [7:0]  b_out_byte;
  logic [1:0]  b_par_err_cnt, b_dat_err_cnt;

  hamming74_nibble_packer #(.LSN_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_code(in_code), .in_syndrome(in_syndrome), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_byte(a_out_byte),
    .out_err(a_out_err), .out_partial(a_out_partial), .cnt_clr(cnt_clr),
    .par_err_cnt(a_par_err_cnt), .dat_err_cnt(a_dat_err_cnt));

  hamming74_nibble_packer #(.LSN_FIRST(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .in_syndrome(in_syndrome), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_byte(b_out_byte),
    .out_err(b_out_err), .out_partial(b_out_partial), .cnt_clr(cnt_clr),
    .par_err_cnt(b_par_err_cnt), .dat_err_cnt(b_dat_err_cnt));

  typedef struct packed {
    logic [7:0] val_a;
    logic [7:0] val_b;
    logic       err;
    logic       partial;
  } exp_t;

  exp_t       exp_q[$];
  int         pend_n;
  logic [3:0] pend_nib;
  logic       pend_err;
  int         par_a, dat_a, par_b, dat_b;
  int         n_cmp, n_mis, n_fired, n_popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [6:0] c);
    int v;
    v = 8 * ((int'(c) >> 6) & 1) + 4 * ((int'(c) >> 5) & 1)
      + 2 * ((int'(c) >> 4) & 1) + ((int'(c) >> 2) & 1);
    return 4'(v);
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_n = 0; pend_nib = 4'h0; pend_err = 1'b0;
    par_a = 0; dat_a = 0; par_b = 0; dat_b = 0;
  endtask

  // One clock: compare DUT to model, advance model by the edge, return whether a codeword fired.
  task automatic tick(output bit fired);
    bit         slot, rdy, fire;
    exp_t       e;
    logic [3:0] n;
    #1;
    slot = (exp_q.size() == 0) || out_ready;
    rdy  = (pend_n == 0) || slot;
    check("a_in_ready", 32'(a_in_ready), 32'(rdy));
    check("b_in_ready", 32'(b_in_ready), 32'(rdy));
    check("a_out_valid", 32'(a_out_valid), 32'(exp_q.size() != 0));
    check("b_out_valid", 32'(b_out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("a_out_byte", 32'(a_out_byte), 32'(exp_q[0].val_a));
      check("b_out_byte", 32'(b_out_byte), 32'(exp_q[0].val_b));
      check("a_out_err", 32'(a_out_err), 32'(exp_q[0].err));
      check("b_out_err", 32'(b_out_err), 32'(exp_q[0].err));
      check("a_out_partial", 32'(a_out_partial), 32'(exp_q[0].partial));
      check("b_out_partial", 32'(b_out_partial), 32'(exp_q[0].partial));
    end
    check("a_par_cnt", 32'(a_par_err_cnt), 32'(par_a));
    check("a_dat_cnt", 32'(a_dat_err_cnt), 32'(dat_a));
    check("b_par_cnt", 32'(b_par_err_cnt), 32'(par_b));
    check("b_dat_cnt", 32'(b_dat_err_cnt), 32'(dat_b));

    fire = in_valid && rdy;
    if (exp_q.size() != 0 && out_ready) begin
      void'(exp_q.pop_front());
      n_popped++;
    end
    if (fire) begin
      n_fired++;
      n = nib_of(in_code);
      if (pend_n == 0) begin
        pend_nib = n; pend_err = (in_syndrome != 3'd0); pend_n = 1;
      end else begin
        e.val_a   = 8'(16 * int'(n) + int'(pend_nib));
        e.val_b   = 8'(16 * int'(pend_nib) + int'(n));
        e.err     = pend_err || (in_syndrome != 3'd0);
        e.partial = 1'b0;
        exp_q.push_back(e);
        pend_n = 0;
      end
    end else if (flush && !in_valid && pend_n == 1 && slot) begin
      e.val_a   = 8'(int'(pend_nib));
      e.val_b   = 8'(16 * int'(pend_nib));
      e.err     = pend_err;
      e.partial = 1'b1;
      exp_q.push_back(e);
      pend_n = 0;
    end
    if (cnt_clr) begin
      par_a = 0; dat_a = 0; par_b = 0; dat_b = 0;
    end else if (fire) begin
      if (in_syndrome == 3'd1 || in_syndrome == 3'd2 || in_syndrome == 3'd4) begin
        par_a = sat_inc(par_a, SAT_A); par_b = sat_inc(par_b, SAT_B);
      end else if (in_syndrome != 3'd0) begin
        dat_a = sat_inc(dat_a, SAT_A); dat_b = sat_inc(dat_b, SAT_B);
      end
    end
    @(posedge clk);
    @(negedge clk);
    fired = fire;
  endtask

  task automatic send(input logic [6:0] c, input logic [2:0] s);
    bit f;
    f = 1'b0;
    in_valid = 1'b1; in_code = c; in_syndrome = s;
    for (int i = 0; i < 40 && !f; i++) tick(f);
    check("send_accepted", 32'(f), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_a_valid"}, 32'(a_out_valid), 32'd0);
    check({tag, "_b_valid"}, 32'(b_out_valid), 32'd0);
    check({tag, "_a_byte"}, 32'(a_out_byte), 32'd0);
    check({tag, "_b_byte"}, 32'(b_out_byte), 32'd0);
    check({tag, "_a_err"}, 32'(a_out_err), 32'd0);
    check({tag, "_a_partial"}, 32'(a_out_partial), 32'd0);
    check({tag, "_a_par"}, 32'(a_par_err_cnt), 32'd0);
    check({tag, "_a_dat"}, 32'(a_dat_err_cnt), 32'd0);
    check({tag, "_b_par"}, 32'(b_par_err_cnt), 32'd0);
  endtask

  initial begin
    bit f;
    int fired0, popped0;
    n_cmp = 0; n_mis = 0; n_fired = 0; n_popped = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_code = 7'h0; in_syndrome = 3'h0;
    flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_regs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pair: 52 then 24 -> 5A (LSN first) / A5 (MSN first)
    send(7'h52, 3'd0);
    send(7'h24, 3'd0);
    #1;
    check("t1_a_valid", 32'(a_out_valid), 32'd1);
    check("t1_a_byte", 32'(a_out_byte), 32'h5A);
    check("t1_b_byte", 32'(b_out_byte), 32'hA5);
    check("t1_a_err", 32'(a_out_err), 32'd0);
    check("t1_a_partial", 32'(a_out_partial), 32'd0);
    tick(f);

    // Data-bit error on second nibble
    send(7'h52, 3'd0);
    send(7'h24, 3'd5);
    #1;
    check("t2_b_byte", 32'(b_out_byte), 32'hA5);
    check("t2_b_err", 32'(b_out_err), 32'd1);
    check("t2_b_dat", 32'(b_dat_err_cnt), 32'd1);
    check("t2_b_par", 32'(b_par_err_cnt), 32'd0);
    tick(f);

    // Backpressure with a byte held and a half-byte pending
    out_ready = 1'b0;
    send(7'h52, 3'd0);
    send(7'h24, 3'd0);
    send(7'h10, 3'd0);
    in_valid = 1'b1; in_code = 7'h24; in_syndrome = 3'd0;
    repeat (3) begin
      tick(f);
      check("t3_blocked", 32'(f), 32'd0);
    end
    #1;
    check("t3_a_in_ready", 32'(a_in_ready), 32'd0);
    check("t3_a_byte_stable", 32'(a_out_byte), 32'h5A);
    out_ready = 1'b1;
    send(7'h24, 3'd0);
    tick(f);
    tick(f);

    // Random stream: 64 codewords under random valid/ready
    fired0 = n_fired; popped0 = n_popped;
    for (int i = 0; i < 3000 && (n_fired - fired0) < 64; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_code     = 7'($urandom);
      in_syndrome = 3'($urandom);
      out_ready   = ($urandom_range(0, 2) != 0);
      tick(f);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick(f);
    check("t3_stream_in", 32'(n_fired - fired0), 32'd64);
    check("t3_stream_out", 32'(n_popped - popped0), 32'd32);

    // Flush a lone nibble, then flush while empty
    send(7'h52, 3'd0);
    flush = 1'b1;
    tick(f);
    #1;
    check("t4_a_byte", 32'(a_out_byte), 32'h0A);
    check("t4_b_byte", 32'(b_out_byte), 32'hA0);
    check("t4_a_partial", 32'(a_out_partial), 32'd1);
    repeat (3) tick(f);
    #1 check("t4_empty_noop", 32'(a_out_valid), 32'd0);
    flush = 1'b0;

    // Counter saturation and clear priority
    cnt_clr = 1'b1;
    tick(f);
    cnt_clr = 1'b0;
    repeat (5) send(7'($urandom), 3'd1);
    #1;
    check("t5_b_par_sat", 32'(b_par_err_cnt), 32'd3);
    check("t5_a_par", 32'(a_par_err_cnt), 32'd5);
    cnt_clr = 1'b1;
    send(7'($urandom), 3'd3);
    cnt_clr = 1'b0;
    #1;
    check("t5_clr_a_dat", 32'(a_dat_err_cnt), 32'd0);
    check("t5_clr_b_par", 32'(b_par_err_cnt), 32'd0);
    tick(f);

    // Reset while HALF with a byte held, then a clean pair
    out_ready = 1'b0;
    send(7'h33, 3'd2);
    send(7'h4C, 3'd0);
    send(7'h52, 3'd0);
    #1 check("t6_pre_valid", 32'(a_out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_regs_zero("t6_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(7'h52, 3'd0);
    send(7'h24, 3'd0);
    #1;
    check("t6_a_byte", 32'(a_out_byte), 32'h5A);
    check("t6_b_byte", 32'(b_out_byte), 32'hA5);
    tick(f);
    tick(f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
